// File: rtl/xrst_settle_sequencer_if.sv
// rtl/xrst_settle_sequencer_if.sv - handshake bundle for the XRST settlement sequencer
// Purpose: groups the evidence intake, participant share and settlement report
//          streams of xrst_settle_sequencer.
// Signals:
//   ev_*   evidence record stream (valid/ready), sla id, reliability, credit, penalty
//   out_*  participant share stream (valid/ready), index, amount, credit flag
//   rpt_*  one-cycle settlement report: sla id, remainder, overallocation flag
// Modports: master = evidence producer / share and report consumer, slave = sequencer.
interface xrst_settle_sequencer_if #(
   parameter int DATA_W = 32
);
   logic              ev_valid;
   logic              ev_ready;
   logic [31:0]       ev_sla_id;
   logic [DATA_W-1:0] ev_reliability;
   logic [DATA_W-1:0] ev_credit;
   logic [DATA_W-1:0] ev_penalty;

   logic              out_valid;
   logic              out_ready;
   logic [3:0]        out_part_idx;
   logic [DATA_W-1:0] out_amount;
   logic              out_is_credit;

   logic              rpt_valid;
   logic [31:0]       rpt_sla_id;
   logic [DATA_W-1:0] rpt_remainder;
   logic              rpt_overalloc;

   modport master (
      output ev_valid, ev_sla_id, ev_reliability, ev_credit, ev_penalty,
      input  ev_ready,
      input  out_valid, out_part_idx, out_amount, out_is_credit,
      output out_ready,
      input  rpt_valid, rpt_sla_id, rpt_remainder, rpt_overalloc
   );

   modport slave (
      input  ev_valid, ev_sla_id, ev_reliability, ev_credit, ev_penalty,
      output ev_ready,
      output out_valid, out_part_idx, out_amount, out_is_credit,
      input  out_ready,
      output rpt_valid, rpt_sla_id, rpt_remainder, rpt_overalloc
   );
endinterface

// File: rtl/xrst_settle_sequencer.sv
// rtl/xrst_settle_sequencer.sv - FIFO-fed evidence tokeniser and weighted share distributor
// Purpose: queues evidence records, turns each into a credit or penalty token against
//          rel_threshold, splits the token over NUM_PART participants by 8-bit weights
//          (one share per handshake), reports each settlement and keeps saturating totals.
// Ports:
//   clk, rst            single clock, synchronous active-high reset
//   bus (slave)         ev_* intake, out_* share stream, rpt_* report pulse
//   rel_threshold       reliability at or above this selects the credit amount
//   part_weight         weight i in bits [8i+7:8i]
//   total_settlements   saturating settlement count
//   total_credits       saturating sum of credit tokens
//   total_penalties     saturating sum of penalty tokens
//   stall_cycles        saturating count of out_valid && !out_ready cycles
// Build option: define XRST_STALL_CNT_EN to build the stall counter; otherwise it reads 0.
module xrst_settle_sequencer #(
   parameter int NUM_PART   = 3,
   parameter int DATA_W     = 32,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   xrst_settle_sequencer_if.slave  bus,
   input  logic [DATA_W-1:0]       rel_threshold,
   input  logic [NUM_PART*8-1:0]   part_weight,
   output logic [31:0]             total_settlements,
   output logic [31:0]             total_credits,
   output logic [31:0]             total_penalties,
   output logic [31:0]             stall_cycles
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int AW = DATA_W + 4;                  // holds up to 16 full shares
   localparam int SW = (DATA_W > 32) ? DATA_W + 1 : 33;

   typedef enum logic [1:0] {S_IDLE, S_TOKENIZE, S_DIST, S_REPORT} state_t;
   state_t state, state_nx;

   logic [31:0]       f_sla  [FIFO_DEPTH];
   logic [DATA_W-1:0] f_rel  [FIFO_DEPTH];
   logic [DATA_W-1:0] f_cr   [FIFO_DEPTH];
   logic [DATA_W-1:0] f_pen  [FIFO_DEPTH];
   logic [PW-1:0]     wr_ptr, rd_ptr;
   logic [PW:0]       count;
   logic              full, push, pop;

   logic [31:0]       w_sla;
   logic [DATA_W-1:0] w_rel, w_cr, w_pen, amt;
   logic              is_credit;
   logic [3:0]        idx;
   logic [AW-1:0]     acc;

   logic              dist_c, rpt_c, hs;
   logic [7:0]        weight;
   logic [DATA_W+7:0] prod;
   logic [DATA_W-1:0] share;
   logic              over;

   function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [DATA_W-1:0] b);
      logic [SW-1:0] s;
      s = SW'(a) + SW'(b);
      return (s > SW'(32'hFFFF_FFFF)) ? 32'hFFFF_FFFF : s[31:0];
   endfunction

   assign full         = (count == (PW+1)'(FIFO_DEPTH));
   assign bus.ev_ready = !full;
   assign push         = bus.ev_valid && !full;

   // Weight lookup by constant-index loop so no variable slice exceeds the vector.
   always_comb begin
      weight = 8'd0;
      for (int i = 0; i < NUM_PART; i++) begin
         if (idx == 4'(i)) weight = part_weight[i*8 +: 8];
      end
   end

   assign prod  = {8'd0, amt} * {{DATA_W{1'b0}}, weight};
   assign share = prod[DATA_W+7:8];
   assign over  = (acc > AW'(amt));

   always_comb begin
      state_nx = state;
      pop      = 1'b0;
      dist_c   = 1'b0;
      rpt_c    = 1'b0;
      hs       = 1'b0;
      case (state)
         S_IDLE: begin
            if (count != '0) begin
               pop      = 1'b1;
               state_nx = S_TOKENIZE;
            end
         end
         S_TOKENIZE: state_nx = S_DIST;
         S_DIST: begin
            dist_c = 1'b1;
            if (bus.out_ready) begin
               hs = 1'b1;
               if (idx == 4'(NUM_PART - 1)) state_nx = S_REPORT;
            end
         end
         S_REPORT: begin
            rpt_c    = 1'b1;
            state_nx = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nx;
   end

   // Storage needs no reset: occupancy is governed entirely by the pointers and count.
   always_ff @(posedge clk) begin
      if (push) begin
         f_sla[wr_ptr] <= bus.ev_sla_id;
         f_rel[wr_ptr] <= bus.ev_reliability;
         f_cr[wr_ptr]  <= bus.ev_credit;
         f_pen[wr_ptr] <= bus.ev_penalty;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr            <= '0;
         rd_ptr            <= '0;
         count             <= '0;
         w_sla             <= '0;
         w_rel             <= '0;
         w_cr              <= '0;
         w_pen             <= '0;
         amt               <= '0;
         is_credit         <= 1'b0;
         idx               <= '0;
         acc               <= '0;
         total_settlements <= '0;
         total_credits     <= '0;
         total_penalties   <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
            w_sla  <= f_sla[rd_ptr];
            w_rel  <= f_rel[rd_ptr];
            w_cr   <= f_cr[rd_ptr];
            w_pen  <= f_pen[rd_ptr];
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (state == S_TOKENIZE) begin
            is_credit <= (w_rel >= rel_threshold);
            amt       <= (w_rel >= rel_threshold) ? w_cr : w_pen;
            idx       <= '0;
            acc       <= '0;
         end
         if (hs) begin
            acc <= acc + AW'(share);
            idx <= idx + 1'b1;
         end
         if (rpt_c) begin
            if (total_settlements != 32'hFFFF_FFFF) total_settlements <= total_settlements + 1'b1;
            if (is_credit) total_credits   <= sat_add(total_credits, amt);
            else           total_penalties <= sat_add(total_penalties, amt);
         end
      end
   end

   assign bus.out_valid     = dist_c;
   assign bus.out_part_idx  = idx;
   assign bus.out_amount    = share;
   assign bus.out_is_credit = is_credit;

   assign bus.rpt_valid     = rpt_c;
   assign bus.rpt_sla_id    = rpt_c ? w_sla : 32'd0;
   assign bus.rpt_overalloc = rpt_c && over;
   assign bus.rpt_remainder = (rpt_c && !over) ? DATA_W'(AW'(amt) - acc) : '0;

`ifdef XRST_STALL_CNT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cycles <= '0;
      end else if (dist_c && !bus.out_ready && stall_cycles != 32'hFFFF_FFFF) begin
         stall_cycles <= stall_cycles + 1'b1;
      end
   end
`else
   assign stall_cycles = 32'd0;
`endif
endmodule

// File: tb/tb_xrst_settle_sequencer.sv
// tb/tb_xrst_settle_sequencer.sv - self-checking bench for xrst_settle_sequencer
module tb_xrst_settle_sequencer;
   localparam int NP = 3;

   logic          clk;
   logic          rst;
   logic [31:0]   thr;
   logic [NP*8-1:0] weights;
   logic [31:0]   tot_set, tot_cr, tot_pen, stall;

   xrst_settle_sequencer_if #(.DATA_W(32)) bus ();

   xrst_settle_sequencer #(.NUM_PART(NP), .DATA_W(32), .FIFO_DEPTH(4)) dut (
      .clk               (clk),
      .rst               (rst),
      .bus               (bus),
      .rel_threshold     (thr),
      .part_weight       (weights),
      .total_settlements (tot_set),
      .total_credits     (tot_cr),
      .total_penalties   (tot_pen),
      .stall_cycles      (stall)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic [31:0] sla;
      logic [31:0] rel;
      logic [31:0] cr;
      logic [31:0] pen;
   } rec_t;

   int          n_tests = 0;
   int          n_fail  = 0;
   rec_t        q[$];
   int          m_idx   = 0;
   longint      m_acc   = 0;
   longint      m_set   = 0, m_cr = 0, m_pen = 0, m_stall = 0;
   int          n_acc   = 0;
   int          n_rpt   = 0;
   logic [31:0] seen_amt[$];
   logic [31:0] rpt_log[$];
   logic [31:0] acc_log[$];
   logic [31:0] last_rem;
   logic        last_ov;
   logic        last_cr;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic longint sat32(input longint v);
      return (v > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : v;
   endfunction

   // Reference model: a queue of accepted records; each settlement is derived from the
   // record at the head using the tokenise/split arithmetic directly.
   always @(negedge clk) begin : monitor
      rec_t        r;
      logic [31:0] amt;
      logic [63:0] e;
      logic        cr;
      if (rst) begin
         q.delete();
         m_idx = 0; m_acc = 0; m_set = 0; m_cr = 0; m_pen = 0; m_stall = 0;
      end else begin
         chk("total_settlements", tot_set, m_set);
         chk("total_credits", tot_cr, m_cr);
         chk("total_penalties", tot_pen, m_pen);
`ifdef XRST_STALL_CNT_EN
         chk("stall_cycles", stall, m_stall);
`else
         chk("stall_cycles", stall, 0);
`endif
         if (bus.ev_valid && bus.ev_ready) begin
            r.sla = bus.ev_sla_id; r.rel = bus.ev_reliability;
            r.cr  = bus.ev_credit; r.pen = bus.ev_penalty;
            q.push_back(r);
            acc_log.push_back(r.sla);
            n_acc++;
         end
         if (bus.out_valid) begin
            if (q.size() == 0 || m_idx >= NP) begin
               chk("out_unexpected", 1, 0);
            end else begin
               r   = q[0];
               cr  = (r.rel >= thr);
               amt = cr ? r.cr : r.pen;
               e   = (64'(amt) * 64'(weights[m_idx*8 +: 8])) >> 8;
               chk("out_part_idx", bus.out_part_idx, m_idx);
               chk("out_amount", bus.out_amount, e);
               chk("out_is_credit", bus.out_is_credit, cr);
               if (bus.out_ready) begin
                  seen_amt.push_back(bus.out_amount);
                  last_cr = bus.out_is_credit;
                  m_acc += longint'(e);
                  m_idx++;
               end else begin
                  m_stall = sat32(m_stall + 1);
               end
            end
         end
         if (bus.rpt_valid) begin
            if (q.size() == 0) begin
               chk("rpt_unexpected", 1, 0);
            end else begin
               r   = q.pop_front();
               cr  = (r.rel >= thr);
               amt = cr ? r.cr : r.pen;
               chk("rpt_sla_id", bus.rpt_sla_id, r.sla);
               chk("rpt_remainder", bus.rpt_remainder, (m_acc > amt) ? 0 : longint'(amt) - m_acc);
               chk("rpt_overalloc", bus.rpt_overalloc, m_acc > amt);
               chk("rpt_share_count", m_idx, NP);
               rpt_log.push_back(bus.rpt_sla_id);
               last_rem = bus.rpt_remainder;
               last_ov  = bus.rpt_overalloc;
               m_set = sat32(m_set + 1);
               if (cr) m_cr  = sat32(m_cr + amt);
               else    m_pen = sat32(m_pen + amt);
               m_acc = 0;
               m_idx = 0;
               n_rpt++;
            end
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step(1);
      rst = 1'b0;
   endtask

   task automatic push(input logic [31:0] sla, input logic [31:0] rel,
                       input logic [31:0] cr, input logic [31:0] pen);
      int n;
      bus.ev_valid = 1'b1; bus.ev_sla_id = sla; bus.ev_reliability = rel;
      bus.ev_credit = cr;  bus.ev_penalty = pen;
      n = 0;
      @(negedge clk);
      while (!bus.ev_ready && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (n >= 300) chk("push_timeout", 1, 0);
      step(1);
      bus.ev_valid = 1'b0;
   endtask

   task automatic wait_rpts(input int target, input int bound);
      int n;
      n = 0;
      while (n_rpt < target && n < bound) begin
         step(1);
         n++;
      end
      if (n_rpt < target) chk("report_timeout", n_rpt, target);
      step(1);
   endtask

   task automatic chk_shares(input string name, input logic [31:0] a0,
                             input logic [31:0] a1, input logic [31:0] a2);
      chk({name, "_count"}, seen_amt.size(), 3);
      if (seen_amt.size() == 3) begin
         chk({name, "_s0"}, seen_amt[0], a0);
         chk({name, "_s1"}, seen_amt[1], a1);
         chk({name, "_s2"}, seen_amt[2], a2);
      end
   endtask

   initial begin : watchdog
      #800000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
      $fatal(1);
   end

   initial begin : stim
      int          base, lat, n;
      logic [3:0]  s_idx;
      logic [31:0] s_amt;
      logic        s_cr, snap;
      rst = 1'b0; thr = 32'd900; weights = '0;
      bus.ev_valid = 1'b0; bus.ev_sla_id = '0; bus.ev_reliability = '0;
      bus.ev_credit = '0; bus.ev_penalty = '0; bus.out_ready = 1'b1;
      step(1);
      do_reset();

      chk("reset_ev_ready", bus.ev_ready, 1);
      chk("reset_out_valid", bus.out_valid, 0);
      chk("reset_rpt_valid", bus.rpt_valid, 0);
      chk("reset_settlements", tot_set, 0);

      // Credit split 128/64/64
      weights = {8'd64, 8'd64, 8'd128};
      seen_amt.delete(); base = n_rpt;
      push(32'd1, 32'd950, 32'd1000, 32'd7);
      wait_rpts(base + 1, 100);
      chk_shares("credit", 500, 250, 250);
      chk("credit_is_credit", last_cr, 1);
      chk("credit_rem", last_rem, 0);
      chk("credit_ov", last_ov, 0);
      chk("credit_settlements", tot_set, 1);
      chk("credit_total", tot_cr, 1000);

      // Penalty split 100/100/50
      weights = {8'd50, 8'd100, 8'd100};
      seen_amt.delete(); base = n_rpt;
      push(32'd2, 32'd500, 32'd5, 32'd300);
      wait_rpts(base + 1, 100);
      chk_shares("penalty", 117, 117, 58);
      chk("penalty_is_credit", last_cr, 0);
      chk("penalty_rem", last_rem, 8);
      chk("penalty_total", tot_pen, 300);

      // Overallocation 200/200/0
      weights = {8'd0, 8'd200, 8'd200};
      seen_amt.delete(); base = n_rpt;
      push(32'd3, 32'd1000, 32'd100, 32'd9);
      wait_rpts(base + 1, 100);
      chk_shares("overalloc", 78, 78, 0);
      chk("overalloc_rem", last_rem, 0);
      chk("overalloc_ov", last_ov, 1);

      // Backpressure: fill FIFO plus working slot with out_ready held low
      weights = {8'd64, 8'd64, 8'd128};
      bus.out_ready = 1'b0; base = n_acc; acc_log.delete(); rpt_log.delete();
      snap = 1'b0; s_idx = '0; s_amt = '0; s_cr = 1'b0;
      for (int k = 0; k < 12; k++) begin
         bus.ev_valid = 1'b1; bus.ev_sla_id = 32'd100 + 32'(k);
         bus.ev_reliability = $urandom_range(0, 2000);
         bus.ev_credit = $urandom_range(0, 5000); bus.ev_penalty = $urandom_range(0, 5000);
         step(1);
         if (bus.out_valid) begin
            if (!snap) begin
               snap = 1'b1; s_idx = bus.out_part_idx; s_amt = bus.out_amount; s_cr = bus.out_is_credit;
            end else begin
               chk("hold_idx", bus.out_part_idx, s_idx);
               chk("hold_amount", bus.out_amount, s_amt);
               chk("hold_is_credit", bus.out_is_credit, s_cr);
            end
         end
      end
      bus.ev_valid = 1'b0;
      chk("full_accepted", n_acc - base, 5);
      chk("full_ev_ready", bus.ev_ready, 0);
      bus.out_ready = 1'b1;
      wait_rpts(n_rpt + 5, 200);
      chk("order_count", rpt_log.size(), 5);
      for (int k = 0; k < 5 && k < rpt_log.size(); k++) chk("order_sla", rpt_log[k], 32'd100 + 32'(k));
`ifdef XRST_STALL_CNT_EN
      chk("stall_held", stall, 9);
`else
      chk("stall_held", stall, 0);
`endif

      // Reset during distribution at idx 1
      bus.out_ready = 1'b0;
      push(32'd200, 32'd950, 32'd800, 32'd1);
      n = 0;
      while (!bus.out_valid && n < 20) begin step(1); n++; end
      bus.out_ready = 1'b1;
      step(1);
      bus.out_ready = 1'b0;
      chk("mid_idx", bus.out_part_idx, 1);
      do_reset();
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_rpt_valid", bus.rpt_valid, 0);
      chk("rst_settlements", tot_set, 0);
      chk("rst_credits", tot_cr, 0);
      chk("rst_penalties", tot_pen, 0);
      chk("rst_stall", stall, 0);
      chk("rst_ev_ready", bus.ev_ready, 1);

      // Latency from accept edge to first out_valid
      bus.out_ready = 1'b1; base = n_rpt;
      push(32'd201, 32'd950, 32'd1000, 32'd1);
      lat = 0;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         if (bus.out_valid) begin lat = k; break; end
      end
      chk("latency", lat, 3);
      wait_rpts(base + 1, 100);
      chk("post_rst_settlements", tot_set, 1);

      // Saturation of credit total
      do_reset();
      base = n_rpt;
      push(32'd300, 32'd1000, 32'hFFFF_FFF0, 32'd0);
      push(32'd301, 32'd1000, 32'hFFFF_FFF0, 32'd0);
      wait_rpts(base + 2, 200);
      chk("sat_credits", tot_cr, 32'hFFFF_FFFF);
      chk("sat_settlements", tot_set, 2);

      // Randomised batches; weights and threshold change only while drained
      do_reset();
      for (int b = 0; b < 4; b++) begin
         weights = {8'($urandom), 8'($urandom), 8'($urandom)};
         thr = $urandom_range(0, 2000);
         for (int c = 0; c < 400; c++) begin
            bus.ev_valid = ($urandom_range(0, 99) < 40);
            bus.ev_sla_id = $urandom;
            bus.ev_reliability = $urandom_range(0, 2000);
            bus.ev_credit  = ($urandom_range(0, 9) == 0) ? $urandom : $urandom_range(0, 100000);
            bus.ev_penalty = ($urandom_range(0, 9) == 0) ? $urandom : $urandom_range(0, 100000);
            bus.out_ready = ($urandom_range(0, 99) < 70);
            step(1);
         end
         bus.ev_valid = 1'b0; bus.out_ready = 1'b1;
         n = 0;
         while (q.size() != 0 && n < 500) begin step(1); n++; end
         chk("drain", q.size(), 0);
         step(2);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/xrst_settle_sequencer.md
Name: xrst_settle_sequencer

Overview:
- Parametrised, self-contained successor to the single-shot XRST settlement flow.
- Queues evidence records in a FIFO, tokenises each record as a credit or a penalty against a reliability threshold, then distributes the token amount across NUM_PART participants by 8-bit weights, one participant per handshake.
- Emits one report per settlement and keeps saturating lifetime counters.
- Sits between evidence intake and the xrbus/settlement report path.

Parameters:
- NUM_PART, 3: number of participants; 2..16.
- DATA_W, 32: width of reliability, credit, penalty and token amounts.
- FIFO_DEPTH, 4: evidence FIFO entries; power of two, >=2.

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- ev_valid  in  1  evidence record valid.
- ev_ready  out  1  FIFO can accept; equals !full.
- ev_sla_id  in  32  SLA identifier.
- ev_reliability  in  DATA_W  reliability score.
- ev_credit  in  DATA_W  credit amount.
- ev_penalty  in  DATA_W  penalty amount.
- rel_threshold  in  DATA_W  score at or above this value selects credit.
- part_weight  in  NUM_PART*8  weight i in bits [8i+7:8i]; quasi-static.
- out_valid  out  1  participant share valid.
- out_ready  in  1  downstream accepts share.
- out_part_idx  out  4  participant index.
- out_amount  out  DATA_W  participant share.
- out_is_credit  out  1  1 = credit, 0 = penalty.
- rpt_valid  out  1  one-cycle settlement report pulse.
- rpt_sla_id  out  32  SLA identifier of the settled record.
- rpt_remainder  out  DATA_W  token amount minus sum of shares, clamped at 0.
- rpt_overalloc  out  1  sum of shares exceeded the token amount.
- total_settlements  out  32  saturating count of settlements.
- total_credits  out  32  saturating sum of credit token amounts.
- total_penalties  out  32  saturating sum of penalty token amounts.
- stall_cycles  out  32  see Optional Feature.

Behaviour:
- Reset:
  - rst high at a clk edge empties the FIFO, forces the FSM to IDLE, clears idx and the accumulator, and zeros every output register and counter.
  - A record in flight is discarded.
  - ev_ready is 1 in the first cycle after reset.
- FIFO:
  - Push when ev_valid && ev_ready.
  - ev_ready is driven combinationally from the occupancy count.
  - When full, ev_ready=0; a pop in the same cycle does not admit a push.
  - Order is strict FIFO; the pointers wrap modulo FIFO_DEPTH.
- FSM IDLE:
  - If the FIFO is non-empty, pop the head into the working registers and go to TOKENIZE; otherwise stay.
- FSM TOKENIZE:
  - If reliability >= rel_threshold, is_credit=1 and amt=credit; otherwise is_credit=0 and amt=penalty.
  - Clear idx and acc; go to DIST.
- FSM DIST:
  - out_valid=1; out_amount = (amt*weight[idx])>>8, computed at DATA_W+8 bits and truncated to DATA_W.
  - All out_* fields stay stable while out_valid && !out_ready.
  - On handshake, acc += share (DATA_W+4 bits) and idx++.
  - The handshake at idx==NUM_PART-1 moves the FSM to REPORT.
- FSM REPORT:
  - rpt_valid=1 for exactly one cycle.
  - If acc > amt, rpt_remainder=0 and rpt_overalloc=1; otherwise rpt_remainder=amt-acc and rpt_overalloc=0.
  - total_settlements increments by 1.
  - total_credits or total_penalties increments by amt.
  - All three counters saturate at 32'hFFFF_FFFF.
  - Next state is IDLE.
- Latency: record accepted at edge T gives out_valid high in cycle T+3 when the FIFO was empty and the FSM was idle.
- Weights are sampled live each DIST cycle; changing them mid-settlement is unsupported but must not hang the FSM.

Optional Feature:
- Macro: XRST_STALL_CNT_EN.
- Defined: stall_cycles counts cycles with out_valid && !out_ready, saturating at all-ones; cleared only by rst.
- Undefined: stall_cycles is tied to 0 and no counter logic is built.

Test Plan:
- Credit split: NUM_PART=3, weights 128/64/64, threshold 900; push reliability 950, credit 1000.
  Required: shares 500/250/250 with out_is_credit=1, rpt_remainder=0, rpt_overalloc=0, total_settlements=1, total_credits=1000.
- Penalty split: weights 100/100/50; push reliability 500, penalty 300.
  Required: shares 117/117/58 with out_is_credit=0, rpt_remainder=8, total_penalties=300.
- Overallocation: weights 200/200/0; push credit 100, reliability 1000.
  Required: shares 78/78/0, rpt_remainder=0, rpt_overalloc=1.
- Backpressure and full: FIFO_DEPTH=4, out_ready held 0, push records continuously.
  Required: exactly 5 records accepted, then ev_ready=0; out_* stable throughout.
  Then release out_ready: all 5 reports arrive in push order. With XRST_STALL_CNT_EN defined, stall_cycles equals the number of held cycles.
- Reset mid-DIST: assert rst for one cycle at idx=1.
  Required: next cycle out_valid=0, rpt_valid=0, all counters 0, ev_ready=1. A new record then settles normally with first out_valid at T+3.
- Saturation: preload total_credits near max by pushing credit 32'hFFFF_FFF0 twice.
  Required: total_credits=32'hFFFF_FFFF and total_settlements=2.
